// File: rtl/noc_ni_tx.sv
// NoC network-interface transmitter: buffers payload words and injects head/body/tail flits into a router L_IN port.
// Optional macro NI_SRC_ID_EN: head flit low byte carries {SRC_X, SRC_Y} instead of {4'b0, cmd_len}.
module noc_ni_tx #(
  parameter int         FIFO_DEPTH = 8,
  parameter logic [3:0] SRC_X      = 4'd0,
  parameter logic [3:0] SRC_Y      = 4'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_dst_x,
  input  logic [3:0]  cmd_dst_y,
  input  logic [3:0]  cmd_len,
  input  logic        pl_valid,
  output logic        pl_ready,
  input  logic [15:0] pl_data,
  output logic [17:0] l_flit,
  input  logic        l_ready,
  output logic        err_len,
  output logic        busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_BODY = 2'b10;
  localparam logic [1:0] T_TAIL = 2'b11;

  typedef enum logic [1:0] {IDLE, HEAD, PAYLOAD} state_t;

  state_t            state, state_n;
  logic [15:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, peek_ptr;
  logic [CNT_W-1:0]  count;
  logic              full, push, pop, xfer, load_word;
  logic [3:0]        rem, rem_n;
  logic [17:0]       flit_n;
  logic [7:0]        head_lo;

`ifdef NI_SRC_ID_EN
  assign head_lo = {SRC_X, SRC_Y};
`else
  logic unused_src;
  assign head_lo    = {4'b0, cmd_len};
  assign unused_src = ^{SRC_X, SRC_Y};
`endif

  assign full     = (count == CNT_W'(FIFO_DEPTH));
  assign pl_ready = !full;
  assign push     = pl_valid && !full;
  assign xfer     = (l_flit[17:16] != T_IDLE) && l_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (cmd_valid && cmd_len != 4'd0) state_n = HEAD;
      HEAD:    if (l_ready) state_n = PAYLOAD;
      PAYLOAD: if (xfer && l_flit[17:16] == T_TAIL) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // The output register always shows the word at the FIFO head; after a pop it
  // peeks one slot ahead so payload flits can go out back to back.
  always_comb begin
    cmd_ready = (state == IDLE);
    busy      = (state != IDLE);
    flit_n    = l_flit;
    rem_n     = rem;
    pop       = 1'b0;
    load_word = 1'b0;
    peek_ptr  = rd_ptr;
    case (state)
      IDLE: begin
        flit_n = 18'h0;
        if (cmd_valid && cmd_len != 4'd0) begin
          flit_n = {T_HEAD, cmd_dst_x, cmd_dst_y, head_lo};
          rem_n  = cmd_len;
        end
      end
      HEAD: if (l_ready) load_word = 1'b1;
      PAYLOAD: begin
        if (xfer) begin
          pop   = 1'b1;
          rem_n = rem - 4'd1;
          if (rem == 4'd1) flit_n = 18'h0;
          else             load_word = 1'b1;
        end else if (l_flit[17:16] == T_IDLE) begin
          load_word = 1'b1;
        end
      end
      default: flit_n = 18'h0;
    endcase
    peek_ptr = rd_ptr + PTR_W'(pop);
    if (load_word) begin
      if (count > CNT_W'(pop)) flit_n = {(rem_n == 4'd1) ? T_TAIL : T_BODY, mem[peek_ptr]};
      else                     flit_n = 18'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pl_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      l_flit  <= 18'h0;
      rem     <= 4'd0;
      err_len <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      l_flit  <= flit_n;
      rem     <= rem_n;
      err_len <= cmd_valid && cmd_ready && (cmd_len == 4'd0);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count   <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule
